nonrestoring_divider: RTL and testbench

- Sequential unsigned integer divider for the ALU datapath: the iterative counterpart of the ripple-carry adder.
- Computes quotient and remainder of an N-bit dividend by an N-bit divisor using the non-restoring algorithm: one add or subtract on the partial remainder per clock.
- Sits beside the adder/multiplier in the ALU execute stage, driven by a start/done handshake from the ALU control unit.

---
 rtl/nonrestoring_divider.sv | 124 ++++++++++++
 tb/tb_nonrestoring_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential unsigned non-restoring divider, one add/subtract per clock
module nonrestoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [N+1:0]  p_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  d_q;
    logic [CW-1:0] cnt_q;

    logic [N+1:0] d_ext;
    logic [N+1:0] s_hi;
    logic [N+1:0] addend;
    logic [N+1:0] p_iter;
    logic [N+1:0] p_corr;
    logic         last_iter;

    // The sign of the old partial remainder picks add or subtract; subtract is ~D plus carry-in 1.
    always_comb begin
        d_ext     = {2'b00, d_q};
        s_hi      = {p_q[N:0], a_q[N-1]};
        addend    = p_q[N+1] ? d_ext : ~d_ext;
        p_iter    = s_hi + addend + {{(N+1){1'b0}}, ~p_q[N+1]};
        p_corr    = p_q[N+1] ? (p_q + d_ext) : p_q;
        last_iter = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (last_iter) begin
                    state_d = S_CORRECT;
                end
            end
            S_CORRECT: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_ITER) || (state_q == S_CORRECT);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            a_q   <= dividend;
                            d_q   <= divisor;
                            p_q   <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                S_ITER: begin
                    p_q   <= p_iter;
                    a_q   <= {a_q[N-2:0], ~p_iter[N+1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_CORRECT: begin
                    p_q         <= p_corr;
                    quotient    <= a_q;
                    remainder   <= p_corr[N-1:0];
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - table-driven and sequence checks for nonrestoring_divider
module tb_nonrestoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    nonrestoring_divider #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_exclusive", int'(busy && done), 0);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input int elat);
        int t0;
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        check("busy_after_accept", int'(busy), int'(b != 0));
        wait_done(n);
        check("latency", cyc - t0 + 1, elat);
        check("quotient", int'(quotient), int'(eq));
        check("remainder", int'(remainder), int'(er));
        check("div_by_zero", int'(div_by_zero), int'(edz));
        @(posedge clk);
        #1;
        check("done_single_pulse", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int n;
        int t0;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 10};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 10};
        vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 10};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 10};
        vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 10};
        vecs[5] = '{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 1};
        vecs[6] = '{8'd200, 8'd16,  8'd12,  8'd8,  1'b0, 10};

        rst = 1'b1;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // 200/3 with stray starts during ITER and during DONE
        @(negedge clk);
        dividend = 8'd200;
        divisor = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd9;
        divisor = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_during_iter", int'(busy), 1);
        wait_done(n);
        check("ignored_latency", cyc - t0 + 1, 10);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_ignored", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_quotient", int'(quotient), 66);
            check("hold_remainder", int'(remainder), 2);
            check("hold_idle_busy", int'(busy), 0);
        end

        // reset at iteration 4 of 250/13
        @(negedge clk);
        dividend = 8'd250;
        divisor = 8'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        check("midrst_dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_stays_idle", int'(done || busy), 0);

        // reset coincident with start drops the start
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_beats_start", int'(busy || done), 0);

        run_div(8'd250, 8'd13, 8'd19, 8'd3, 1'b0, 10);

        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            case (i % 8)
                0: ra = 8'd0;
                1: rb = 8'd255;
                2: ra = 8'd255;
                3: rb = 8'd0;
                default: ;
            endcase
            if (rb == 8'd0) begin
                run_div(ra, rb, 8'hFF, ra, 1'b1, 1);
            end else begin
                run_div(ra, rb, ra / rb, ra % rb, 1'b0, 10);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
